char_tx: RTL
============

Name: char_tx

Overview:
- Serial character transmitter; the transmit-side counterpart of the bit-index/character-received receiver chain.
- Accepts one 8-bit character per handshake and serialises it as one frame: start bit 0, 8 data bits LSB first, stop bit 1. Idle line is 1.
- Each bit is held for BIT_CLKS clocks, matching the receiver's sample-counter period. Pulses char_sent at end of frame, the analogue of the receiver's charRec.

Parameters:
- BIT_CLKS, 16, clocks per serial bit; legal range 2..256.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; low aborts any frame and holds the block idle.
- tx_start  input  1  request to send tx_data; sampled only when ready=1.
- tx_data  input  8  character to send; captured on the accept cycle.
- ready  output  1  1 when a new character can be accepted.
- tx_out  output  1  serial line.
- char_sent  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, tx_out=1, ready=0 while held, char_sent=0, all counters 0, shift register 0.
- ready = (state==IDLE) & enable; combinational from registered state.
- Accept: on the rising edge where ready=1 and tx_start=1, capture tx_data into the shift register. Enter START and drive tx_out=0 from that edge. Latency from accept edge to start-bit edge is 0 cycles.
- States and transitions:
  - IDLE -> START on accept.
  - START: tx_out=0 for BIT_CLKS clocks, then -> DATA with bit index 0.
  - DATA: tx_out=shift[0] for BIT_CLKS clocks, then shift right and increment the bit index. After bit index 7 completes, -> STOP.
  - STOP: tx_out=1 for BIT_CLKS clocks, then -> IDLE and assert char_sent for exactly one cycle.
- Frame length is 10*BIT_CLKS clocks from the accept edge to the edge entering IDLE.
- Clock divider counts 0..BIT_CLKS-1. It resets to 0 on accept and on every bit boundary, and wraps without ever reaching BIT_CLKS.
- Bit index counts 0..7 only in DATA and is cleared on entering DATA.
- tx_start while ready=0 is ignored, not queued.
- tx_data changes after the accept edge have no effect on the current frame.
- Back-to-back: ready is 1 on the char_sent cycle. An accept there starts the next start bit immediately, with no idle bit between the stop bit and the next start bit.
- enable falling in any non-IDLE state: on the next edge go to IDLE, tx_out=1, counters cleared, no char_sent. The frame is truncated, and a receiver must discard it.
- enable low in IDLE: stay in IDLE with ready=0.
- reset_n asserted mid-frame: immediate IDLE, tx_out=1, no char_sent.
- tx_out is driven from a flop; it never glitches and never goes high-Z.

Decomposition:
- Shared package char_link_pkg holds:
  - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1, DATA_BITS=8;
  - the state enum {IDLE, START, DATA, STOP}.
  - The receiver side uses the same package.
- One natural sub-module, char_tx_bitclk: BIT_CLKS divider with clear input and a bit_done pulse. The FSM, shift register and bit index stay in char_tx.

Test Plan:
- Reset then idle: reset_n pulsed low mid-simulation -> tx_out=1, ready=1 (enable=1), char_sent=0 for 50 cycles with no tx_start.
- Single frame, BIT_CLKS=16, tx_data=0x55 -> tx_out sampled at bit centres reads 0,1,0,1,0,1,0,1,0,1. char_sent pulses once, 160 cycles after the accept edge, and ready returns to 1 on that same cycle.
- Back-to-back 0x00 then 0xFF, with tx_start held high -> second start bit begins on the char_sent cycle of the first frame. Line sequence is 0,0x8,1,0,1x8,1 with no gap; two char_sent pulses exactly 160 cycles apart.
- Ignored request: tx_start pulsed with tx_data=0xAA at cycle 40 of a 0x3C frame -> 0x3C frame unaffected, exactly one char_sent, no 0xAA frame follows.
- Abort: enable dropped during data bit 3 of 0xC3 -> next edge tx_out=1, no char_sent. After enable returns, a 0x81 frame transmits correctly from a cleared bit index.
- Divider boundary, BIT_CLKS=2, tx_data=0x01 -> each bit lasts exactly 2 cycles, frame is 20 cycles, and char_sent lands on cycle 20.

Source files
------------

// File: rtl/char_link_pkg.sv
// -----------------------------------------------------------------------------
// char_link_pkg
// Definitions shared by the serial character transmitter and receiver:
// the line levels of a frame and the frame state encoding.
// No ports; imported by the char_tx files.
// -----------------------------------------------------------------------------
package char_link_pkg;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } char_state_e;

endpackage

// File: rtl/char_tx_if.sv
// -----------------------------------------------------------------------------
// char_tx_if
// Character handshake between a producer (master) and the transmitter (slave).
//   tx_start  : request to send tx_data (honoured only while ready=1)
//   tx_data   : character to send, captured on the accept edge
//   ready     : transmitter can accept a character this cycle
//   char_sent : one-cycle pulse after the stop bit of a frame completes
// -----------------------------------------------------------------------------
interface char_tx_if;
    import char_link_pkg::*;

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 ready;
    logic                 char_sent;

    modport master (
        output tx_start,
        output tx_data,
        input  ready,
        input  char_sent
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output ready,
        output char_sent
    );

endinterface

// File: rtl/char_tx_bitclk.sv
// -----------------------------------------------------------------------------
// char_tx_bitclk
// Bit-period divider. While run=1 the counter walks 0..BIT_CLKS-1 and wraps;
// bit_done is high on the last clock of each bit period.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   run      : count enable (a frame is in progress)
//   clr      : force the counter back to 0 (accept / abort)
//   bit_done : last clock of the current bit period
// -----------------------------------------------------------------------------
module char_tx_bitclk #(
    parameter int BIT_CLKS = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clr,
    output logic bit_done
);

    localparam int               CNT_W    = $clog2(BIT_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: held at 0 when idle or cleared, wraps after the last clock.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !run) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = run && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/char_tx.sv
// -----------------------------------------------------------------------------
// char_tx
// Serial character transmitter. Each accepted character becomes one frame:
// start bit (0), DATA_BITS data bits LSB first, stop bit (1), each bit held for
// BIT_CLKS clocks. The line idles high. char_sent pulses for one cycle on
// return to IDLE; ready is already high in that cycle so frames can be chained.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   enable   : block enable; low aborts any frame and keeps the block idle
//   tx_if    : character handshake (tx_start, tx_data, ready, char_sent)
//   tx_out   : serial line, registered
// -----------------------------------------------------------------------------
module char_tx #(
    parameter int BIT_CLKS  = 16,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    char_tx_if.slave   tx_if,
    output logic       tx_out
);

    import char_link_pkg::*;

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    char_state_e          state_q;
    char_state_e          state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
    logic                 tx_out_q;
    logic                 tx_out_d;
    logic                 char_sent_q;
    logic                 char_sent_d;
    logic                 alive_q;
    logic                 alive_d;

    logic ready_s;
    logic accept_s;
    logic bit_done_s;
    logic div_run_s;
    logic div_clr_s;

    // alive_q keeps ready low while reset is held and for the first edge after.
    assign ready_s   = (state_q == IDLE) && enable && alive_q;
    assign accept_s  = ready_s && tx_if.tx_start;
    assign div_run_s = (state_q != IDLE);
    assign div_clr_s = accept_s || !enable;

    char_tx_bitclk #(
        .BIT_CLKS (BIT_CLKS)
    ) u_bitclk (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (div_run_s),
        .clr      (div_clr_s),
        .bit_done (bit_done_s)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a low enable forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                    end
                end
                DATA: begin
                    if (bit_done_s && (bit_idx_q == IDX_LAST)) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = STOP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath and output values for the next cycle.
    always_comb begin
        shift_d     = shift_q;
        bit_idx_d   = '0;
        char_sent_d = 1'b0;
        alive_d     = 1'b1;
        if (!enable) begin
            shift_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        shift_d = tx_if.tx_data;
                    end else begin
                        shift_d = shift_q;
                    end
                end
                START: begin
                    shift_d = shift_q;
                end
                DATA: begin
                    if (bit_done_s) begin
                        shift_d = shift_q >> 1;
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_d = '0;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        bit_idx_d = bit_idx_q;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        char_sent_d = 1'b1;
                    end else begin
                        char_sent_d = 1'b0;
                    end
                end
                default: begin
                    shift_d = '0;
                end
            endcase
        end

        // Line level follows the state being entered, so the start bit
        // appears on the accept edge itself.
        case (state_d)
            START:   tx_out_d = START_BIT;
            DATA:    tx_out_d = shift_d[0];
            STOP:    tx_out_d = STOP_BIT;
            default: tx_out_d = IDLE_LEVEL;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_out_q    <= IDLE_LEVEL;
            char_sent_q <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_out_q    <= tx_out_d;
            char_sent_q <= char_sent_d;
            alive_q     <= alive_d;
        end
    end

    assign tx_if.ready     = ready_s;
    assign tx_if.char_sent = char_sent_q;
    assign tx_out          = tx_out_q;

endmodule
